// File: rtl/gb_interrupt_ctrl_pkg.sv
// gb_interrupt_pkg: shared constants and types for the DMG interrupt controller.
//   - IF/IE register addresses on the I/O bus
//   - IF bit indices per interrupt source
//   - dispatch vectors and the cancel vector
//   - dispatch FSM state type
package gb_interrupt_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam logic [15:0] VEC_VBLANK = 16'h0040;
  localparam logic [15:0] VEC_STAT   = 16'h0048;
  localparam logic [15:0] VEC_TIMER  = 16'h0050;
  localparam logic [15:0] VEC_SERIAL = 16'h0058;
  localparam logic [15:0] VEC_JOYPAD = 16'h0060;
  localparam logic [15:0] VEC_CANCEL = 16'h0000;

  typedef enum logic [0:0] {IDLE, ACK} int_state_t;

  function automatic logic [15:0] irq_vector(input int idx);
    case (idx)
      IRQ_VBLANK: irq_vector = VEC_VBLANK;
      IRQ_STAT:   irq_vector = VEC_STAT;
      IRQ_TIMER:  irq_vector = VEC_TIMER;
      IRQ_SERIAL: irq_vector = VEC_SERIAL;
      IRQ_JOYPAD: irq_vector = VEC_JOYPAD;
      default:    irq_vector = VEC_CANCEL;
    endcase
  endfunction

endpackage

// File: rtl/gb_interrupt_ctrl_if.sv
// gb_interrupt_ctrl_if: I/O bus and CPU dispatch handshake of the interrupt controller.
//   addr/wren/data_i : register address, write strobe, write data (from bus master)
//   data_o           : combinational read data
//   ime/int_ack      : CPU master enable and dispatch acknowledge (level)
//   int_req          : dispatch request to CPU
//   int_vector       : handler address, valid while dispatching
//   int_pending      : any enabled interrupt flagged (HALT wake), independent of ime
interface gb_interrupt_ctrl_if;

  logic [15:0] addr;
  logic        wren;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        ime;
  logic        int_ack;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_pending;

  modport master (
    output addr, wren, data_i, ime, int_ack,
    input  data_o, int_req, int_vector, int_pending
  );

  modport slave (
    input  addr, wren, data_i, ime, int_ack,
    output data_o, int_req, int_vector, int_pending
  );

endinterface

// File: rtl/gb_irq_priority_enc.sv
// gb_irq_priority_enc: fixed-priority encoder over pending interrupts, bit 0 highest.
//   pend   : enabled & flagged interrupt bits
//   clr    : one-hot mask of the winning bit (zero when nothing pending)
//   vector : handler address of the winner, VEC_CANCEL when nothing pending
//   valid  : at least one bit pending
module gb_irq_priority_enc
  import gb_interrupt_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic [NUM_IRQ-1:0] clr,
  output logic [15:0]        vector,
  output logic               valid
);

  always_comb begin
    clr    = '0;
    vector = VEC_CANCEL;
    valid  = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        clr    = '0;
        clr[i] = 1'b1;
        vector = irq_vector(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// gb_interrupt_ctrl: DMG interrupt controller (IF at FF0F, IE at FFFF).
//   clk, reset            : M clock, asynchronous active-high reset
//   bus (slave modport)   : register access and CPU dispatch handshake
//   irq_vblank..irq_joypad: peripheral request inputs, IF bits 0..4
// Build option GB_IRQ_EDGE_DETECT_EN: when defined, requests set IF only on a
// 0->1 transition of each irq input; otherwise IF sets on every high cycle.
module gb_interrupt_ctrl
  import gb_interrupt_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  gb_interrupt_ctrl_if.slave   bus,
  input  logic                 irq_vblank,
  input  logic                 irq_stat,
  input  logic                 irq_timer,
  input  logic                 irq_serial,
  input  logic                 irq_joypad
);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] irq_in, irq_set, pend, enc_clr;
  logic [15:0]        enc_vector, vec_q, vec_d;
  logic               enc_valid;
  int_state_t         state_q, state_d;
  logic               entry_q, go_ack, int_req;
  logic               wr_if, wr_ie, ack_entry;

  assign irq_in = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};

`ifdef GB_IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_prev_q <= '0;
    else       irq_prev_q <= irq_in;
  end

  assign irq_set = irq_in & ~irq_prev_q;
`else
  assign irq_set = irq_in;
`endif

  assign wr_if = bus.wren && (bus.addr == ADDR_IF);
  assign wr_ie = bus.wren && (bus.addr == ADDR_IE);
  assign pend  = ie_q[NUM_IRQ-1:0] & if_q;

  gb_irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_enc (
    .pend   (pend),
    .clr    (enc_clr),
    .vector (enc_vector),
    .valid  (enc_valid)
  );

  // Vector and clear are taken in the first ACK cycle, so a CPU rewrite of IE/IF
  // during the push (the transition cycle) can still cancel the dispatch.
  assign ack_entry = (state_q == ACK) && entry_q;

  always_comb begin
    if_d = wr_if ? bus.data_i[NUM_IRQ-1:0] : if_q;
    if (ack_entry) if_d = if_d & ~enc_clr;
    if_d = if_d | irq_set;  // a new request beats a same-cycle clear
  end

  always_comb begin
    state_d = state_q;
    go_ack  = 1'b0;
    int_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        int_req = bus.ime && (|pend);
        if (int_req && bus.int_ack) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end
      end
      ACK: begin
        if (!bus.int_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_d = ack_entry ? (enc_valid ? enc_vector : VEC_CANCEL) : vec_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= '0;
      state_q <= IDLE;
      entry_q <= 1'b0;
      vec_q   <= VEC_CANCEL;
    end else begin
      if_q    <= if_d;
      if (wr_ie) ie_q <= bus.data_i;
      state_q <= state_d;
      entry_q <= go_ack;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    if (bus.addr == ADDR_IF)      bus.data_o = {{(8 - NUM_IRQ){1'b1}}, if_q};
    else if (bus.addr == ADDR_IE) bus.data_o = ie_q;
    else                          bus.data_o = 'x;
  end

  assign bus.int_req     = int_req;
  assign bus.int_vector  = vec_q;
  assign bus.int_pending = |pend;

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb_gb_interrupt_ctrl: directed scoreboard bench for gb_interrupt_ctrl.
// Stimulus pushes hand-computed expectations; a monitor on the falling edge
// pops and compares them against the DUT outputs of the current cycle.
module tb_gb_interrupt_ctrl;

  localparam int S_DATA = 0;
  localparam int S_REQ  = 1;
  localparam int S_VEC  = 2;
  localparam int S_PEND = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t q[$];

  gb_interrupt_ctrl_if bus ();

  gb_interrupt_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .irq_vblank (irq_vblank),
    .irq_stat   (irq_stat),
    .irq_timer  (irq_timer),
    .irq_serial (irq_serial),
    .irq_joypad (irq_joypad)
  );

  always #5 clk = ~clk;

  // Monitor / scoreboard
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.sel)
        S_DATA:  act = {8'h00, bus.data_o};
        S_REQ:   act = {15'h0000, bus.int_req};
        S_VEC:   act = bus.int_vector;
        default: act = {15'h0000, bus.int_pending};
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_miss++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wren   = 1'b0;
    irq_vblank = 1'b0;
    irq_stat   = 1'b0;
    irq_timer  = 1'b0;
    irq_serial = 1'b0;
    irq_joypad = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.wren   = 1'b1;
    bus.addr   = a;
    bus.data_i = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.addr   = 16'hFF0F;
    bus.wren   = 1'b0;
    bus.data_i = 8'h00;
    bus.ime    = 1'b0;
    bus.int_ack = 1'b0;
    irq_vblank = 1'b0;
    irq_stat   = 1'b0;
    irq_timer  = 1'b0;
    irq_serial = 1'b0;
    irq_joypad = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_if", S_DATA, 16'h00E0);
    chk("rst_req", S_REQ, 16'h0);
    chk("rst_vec", S_VEC, 16'h0);
    chk("rst_pend", S_PEND, 16'h0);
    cyc();
    bus.addr = 16'hFFFF;
    chk("rst_ie", S_DATA, 16'h0000);
    cyc();
    reset = 1'b0;
    cyc();

    // Held request level vs. an IF clear (edge-detect option)
    irq_timer = 1'b1;
    cyc();
    irq_timer = 1'b1;
    wr(16'hFF0F, 8'h00);
    cyc();
    irq_timer = 1'b1;
    bus.addr  = 16'hFF0F;
`ifdef GB_IRQ_EDGE_DETECT_EN
    chk("lvl_if", S_DATA, 16'h00E0);
`else
    chk("lvl_if", S_DATA, 16'h00E4);
`endif
    cyc();
    wr(16'hFF0F, 8'h00);
    cyc();

    // Basic timer dispatch
    wr(16'hFFFF, 8'h04);
    bus.ime = 1'b1;
    cyc();
    irq_timer = 1'b1;
    bus.addr  = 16'hFF0F;
    chk("t1_req_pre", S_REQ, 16'h0);
    cyc();
    chk("t1_if", S_DATA, 16'h00E4);
    chk("t1_req", S_REQ, 16'h1);
    chk("t1_pend", S_PEND, 16'h1);
    bus.int_ack = 1'b1;
    cyc();
    chk("t1_req_ack", S_REQ, 16'h0);
    cyc();
    chk("t1_vec", S_VEC, 16'h0050);
    chk("t1_if_clr", S_DATA, 16'h00E0);
    chk("t1_pend_clr", S_PEND, 16'h0);
    bus.int_ack = 1'b0;
    cyc();
    chk("t1_idle_req", S_REQ, 16'h0);
    cyc();

    // Priority: vblank before joypad
    wr(16'hFFFF, 8'h1F);
    cyc();
    irq_vblank = 1'b1;
    irq_joypad = 1'b1;
    bus.addr   = 16'hFF0F;
    cyc();
    chk("t2_if", S_DATA, 16'h00F1);
    bus.int_ack = 1'b1;
    cyc();
    cyc();
    chk("t2_vec", S_VEC, 16'h0040);
    chk("t2_if_clr", S_DATA, 16'h00F0);
    bus.int_ack = 1'b0;
    cyc();
    chk("t2_req2", S_REQ, 16'h1);
    bus.int_ack = 1'b1;
    cyc();
    cyc();
    chk("t2_vec2", S_VEC, 16'h0060);
    chk("t2_if_clr2", S_DATA, 16'h00E0);
    bus.int_ack = 1'b0;
    cyc();

    // ime gating: pending without request, combinational ime response
    bus.ime = 1'b0;
    wr(16'hFFFF, 8'h02);
    cyc();
    irq_stat = 1'b1;
    bus.addr = 16'hFF0F;
    cyc();
    chk("t3_req", S_REQ, 16'h0);
    chk("t3_pend", S_PEND, 16'h1);
    cyc();
    bus.ime = 1'b1;
    chk("t3_req_ime", S_REQ, 16'h1);
    cyc();
    bus.ime = 1'b0;
    chk("t3_req_drop", S_REQ, 16'h0);
    cyc();
    wr(16'hFF0F, 8'h00);
    cyc();
    chk("t3_pend_clr", S_PEND, 16'h0);
    cyc();

    // Cancel quirk: IE cleared during the push cycle
    bus.ime = 1'b1;
    wr(16'hFFFF, 8'h04);
    cyc();
    irq_timer = 1'b1;
    cyc();
    chk("t4_req", S_REQ, 16'h1);
    bus.int_ack = 1'b1;
    wr(16'hFFFF, 8'h00);
    cyc();
    bus.addr = 16'hFF0F;
    chk("t4_req_ack", S_REQ, 16'h0);
    cyc();
    chk("t4_vec", S_VEC, 16'h0000);
    chk("t4_if", S_DATA, 16'h00E4);
    bus.int_ack = 1'b0;
    cyc();
    wr(16'hFF0F, 8'h00);
    cyc();

    // Set wins over clear in the ACK entry cycle, then reset mid-dispatch
    wr(16'hFFFF, 8'h04);
    cyc();
    irq_timer = 1'b1;
    cyc();
    bus.addr = 16'hFF0F;
    chk("t5_req", S_REQ, 16'h1);
    bus.int_ack = 1'b1;
    cyc();
    irq_timer  = 1'b1;
    irq_serial = 1'b1;
    cyc();
    chk("t5_vec", S_VEC, 16'h0050);
    chk("t5_if", S_DATA, 16'h00EC);
    chk("t5_pend", S_PEND, 16'h1);
    cyc();
    reset = 1'b1;
    chk("t5_rst_req", S_REQ, 16'h0);
    chk("t5_rst_vec", S_VEC, 16'h0000);
    chk("t5_rst_pend", S_PEND, 16'h0);
    chk("t5_rst_if", S_DATA, 16'h00E0);
    cyc();
    bus.addr    = 16'hFFFF;
    bus.int_ack = 1'b0;
    chk("t5_rst_ie", S_DATA, 16'h0000);
    cyc();
    reset = 1'b0;
    cyc();

    @(negedge clk);
    #1;
    if (bus.int_req !== 1'b0) begin
      n_miss++;
      $display("FAIL end_req: got %b, expected 0", bus.int_req);
    end
    if (bus.int_vector !== 16'h0000) begin
      n_miss++;
      $display("FAIL end_vec: got %h, expected 0000", bus.int_vector);
    end
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d expectations not consumed", q.size());
    end
    if (n_vec < 12) begin
      n_miss++;
      $display("FAIL coverage: only %0d vectors compared", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
